lb3x3_channel_sequencer: RTL and testbench
==========================================

Name: lb3x3_channel_sequencer

Overview:
- Controller that drives the 3x3 line-buffer window generator across a multi-channel feature map.
- Accepts one layer command, then for each channel:
  - pulses the line buffer's start and configuration inputs;
  - streams H*W pixels from a channel-major feature-map SRAM (1-cycle read latency) into the line buffer;
  - waits until every expected window has been consumed downstream.
- Pulses done after the last channel and presents the current channel index as a tag for the downstream MAC array.

Parameters:
- DATA_W, 8, pixel width.
- MAX_IMG_W, 224, maximum image width.
- MAX_IMG_H, 224, maximum image height.
- MAX_CH, 1024, maximum channel count.
- ADDR_W, 20, SRAM word address width.
- COL_W, clog2(MAX_IMG_W) (min 1), column/width field width.
- ROW_W, clog2(MAX_IMG_H) (min 1), row/height/stride field width.
- CH_W, clog2(MAX_CH+1), channel count width.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, layer command valid.
- cmd_ready, out, 1, high only in IDLE.
- cmd_img_h, in, ROW_W, image height.
- cmd_img_w, in, COL_W, image width.
- cmd_stride, in, ROW_W, stride (0 treated as 1).
- cmd_channels, in, CH_W, channel count.
- cmd_base_addr, in, ADDR_W, address of pixel (ch0, r0, c0).
- abort, in, 1, synchronous abort of the current layer.
- mem_rd_en, out, 1, SRAM read strobe.
- mem_rd_addr, out, ADDR_W, SRAM read address.
- mem_rd_data, in, DATA_W (signed), data returned one cycle after mem_rd_en.
- lb_start, out, 1, line-buffer start pulse.
- lb_cfg_img_h, out, ROW_W, latched height.
- lb_cfg_img_w, out, COL_W, latched width.
- lb_cfg_stride, out, ROW_W, latched stride.
- lb_in_valid, out, 1, pixel valid to line buffer.
- lb_in_ready, in, 1, line-buffer ready.
- lb_in_data, out, DATA_W (signed), pixel to line buffer.
- lb_win_fire, in, 1, high for each cycle where line-buffer out_valid and out_ready are both high.
- out_channel, out, CH_W, channel currently in flight.
- busy, out, 1, not IDLE.
- done, out, 1, one-cycle layer-complete pulse.
- err, out, 1, one-cycle bad-command pulse.

Behaviour:
- Reset values: all outputs 0, except cmd_ready = 1. lb_cfg_* = 0. State IDLE. Skid FIFO empty.

- IDLE:
  - cmd_ready = 1. On cmd_valid, latch the command; stride 0 is stored as 1.
  - Bad command if any of: H<3, W<3, H>MAX_IMG_H, W>MAX_IMG_W, channels==0, channels>MAX_CH.
  - Bad command: pulse err the next cycle and stay in IDLE; no lb_start, no reads.
  - Good command: go to START with ch=0 and addr=base.

- START:
  - Drive lb_start=1 for exactly one cycle, with lb_in_valid=0 and mem_rd_en=0.
  - Clear the per-channel counters: row, col, row_mod, col_mod, expected, seen.
  - Go to STREAM.

- STREAM:
  - Reads go through a 2-entry skid FIFO. Issue mem_rd_en when (fifo_count + inflight) < 2 and issued < H*W.
  - mem_rd_addr increments by 1 per read, wrapping modulo 2^ADDR_W. Channel base = previous channel end, i.e. addresses are contiguous across channels.
  - Returned data enters the FIFO the cycle after each read.
  - lb_in_valid = FIFO non-empty. lb_in_data = FIFO head. A pop occurs on lb_in_valid && lb_in_ready.
  - Each pop advances the controller's shadow row/col plus row_mod/col_mod counters. Mod counters wrap at stride, so no divider is used.
  - expected++ when the popped pixel has row>=2, col>=2, row_mod==0 and col_mod==0.
  - After the H*W-th pop, go to DRAIN.

- Window counting (all states except IDLE): lb_win_fire increments seen. This includes the same cycle as a pop; both counters update independently.

- DRAIN:
  - Wait until seen == expected. It must not pulse lb_start earlier, because start would drop a pending window.
  - Then go to NEXT.

- NEXT:
  - If ch == channels-1, go to DONE.
  - Otherwise ch++ and go to START.
  - out_channel always equals ch.

- DONE: pulse done for one cycle, then IDLE.

- abort (in any non-IDLE state):
  - Next cycle: pulse lb_start to flush the line buffer, discard FIFO contents and in-flight reads, and return to IDLE.
  - done and err are not pulsed. abort in IDLE is ignored.

- Widths and limits:
  - Counters are sized to hold MAX_IMG_W*MAX_IMG_H.
  - lb_win_fire arriving while seen == expected in DRAIN cannot occur legally; it is ignored (no overflow past expected).

- Backpressure:
  - lb_in_ready low for any duration loses no pixel.
  - At most 2 outstanding reads plus buffered data at any time.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - Adds output perf_stall_cycles[31:0], counting STREAM cycles with FIFO non-empty and lb_in_ready=0.
  - Adds output perf_drain_cycles[31:0], counting DRAIN cycles.
  - Both clear on cmd acceptance and saturate at all-ones.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- H=4, W=4, stride=1, channels=1, base=0x100, lb_in_ready and out_ready always high:
  - exactly 16 reads, at 0x100–0x10F, in order;
  - expected=4, and 4 lb_win_fire events;
  - one lb_start; done pulses once after the 4th window.
- H=5, W=5, stride=2, channels=3, base=0:
  - lb_start pulses 3 times; reads at 0–74 contiguous;
  - 4 windows per channel; out_channel steps 0, 1, 2; done pulses once.
- Same as scenario 1, but lb_in_ready toggled randomly at 50% and lb_win_fire delayed up to 10 cycles:
  - pixel sequence delivered equals the SRAM contents, with no loss or duplicates;
  - next lb_start only after seen==expected.
- Commands (H=2, W=8, ch=1), (H=8, W=8, ch=0), (W=MAX_IMG_W+1): each gives an err pulse, no mem_rd_en, no lb_start, cmd_ready high again the next cycle.
- abort asserted mid-STREAM of channel 1 (of 3): lb_start pulses once, busy drops, no done pulse. A new command (H=3, W=3, ch=1) then completes with 1 window.
- stride=0 with H=3, W=3: lb_cfg_stride=1, expected=1, done pulses.

Source files
------------

// File: rtl/lb3x3_channel_sequencer.sv
// lb3x3_channel_sequencer
// Walks a channel-major feature map through the 3x3 line-buffer window
// generator one channel at a time: start/configure the line buffer, stream
// H*W pixels from SRAM through a 2-entry skid FIFO, then wait until every
// window the controller predicted has been consumed before the next channel.
// Optional build macro: SEQ_PERF_CNT_EN adds stall/drain performance counters.
module lb3x3_channel_sequencer #(
    parameter int DATA_W    = 8,
    parameter int MAX_IMG_W = 224,
    parameter int MAX_IMG_H = 224,
    parameter int MAX_CH    = 1024,
    parameter int ADDR_W    = 20,
    parameter int COL_W     = (MAX_IMG_W > 1) ? $clog2(MAX_IMG_W) : 1,
    parameter int ROW_W     = (MAX_IMG_H > 1) ? $clog2(MAX_IMG_H) : 1,
    parameter int CH_W      = $clog2(MAX_CH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ROW_W-1:0]         cmd_img_h,
    input  logic [COL_W-1:0]         cmd_img_w,
    input  logic [ROW_W-1:0]         cmd_stride,
    input  logic [CH_W-1:0]          cmd_channels,
    input  logic [ADDR_W-1:0]        cmd_base_addr,
    input  logic                     abort,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic signed [DATA_W-1:0] mem_rd_data,
    output logic                     lb_start,
    output logic [ROW_W-1:0]         lb_cfg_img_h,
    output logic [COL_W-1:0]         lb_cfg_img_w,
    output logic [ROW_W-1:0]         lb_cfg_stride,
    output logic                     lb_in_valid,
    input  logic                     lb_in_ready,
    output logic signed [DATA_W-1:0] lb_in_data,
    input  logic                     lb_win_fire,
    output logic [CH_W-1:0]          out_channel,
    output logic                     busy,
    output logic                     done,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0]              perf_stall_cycles,
    output logic [31:0]              perf_drain_cycles,
`endif
    output logic                     err
);

    // Pixel/window counters must hold a full MAX_IMG_W x MAX_IMG_H frame.
    localparam int PIX_W = $clog2(MAX_IMG_W * MAX_IMG_H + 1);

    localparam logic [PIX_W-1:0]  PIX_ONE  = PIX_W'(1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0]  ROW_TWO  = ROW_W'(2);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0]  COL_TWO  = COL_W'(2);
    localparam logic [CH_W-1:0]   CH_ONE   = CH_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5,
        S_ABORT  = 3'd6
    } state_t;

    state_t state_reg, state_next;

    // Latched layer command
    logic [ROW_W-1:0]  cfg_h_reg;
    logic [COL_W-1:0]  cfg_w_reg;
    logic [ROW_W-1:0]  cfg_stride_reg;
    logic [CH_W-1:0]   chans_reg;
    logic [CH_W-1:0]   ch_reg;
    logic [PIX_W-1:0]  total_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              err_reg;

    // Skid FIFO between SRAM return path and the line buffer
    logic signed [DATA_W-1:0] fifo_mem [0:1];
    logic                     fifo_wr_ptr_reg;
    logic                     fifo_rd_ptr_reg;
    logic [1:0]               fifo_cnt_reg;
    logic                     rd_pend_reg;
    logic [1:0]               fifo_occ;
    logic                     fifo_push;
    logic                     fifo_pop;

    // Per-channel progress
    logic [PIX_W-1:0] issued_reg;
    logic [PIX_W-1:0] popped_reg;
    logic [PIX_W-1:0] expected_reg;
    logic [PIX_W-1:0] seen_reg;
    logic [ROW_W-1:0] row_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_mod_reg;
    logic [ROW_W-1:0] col_mod_reg;

    logic cmd_bad;
    logic cmd_accept;
    logic last_pop;
    logic last_ch;
    logic win_hit;
    logic drain_done;

    // Reads in flight plus data already buffered; never allowed past 2.
    assign fifo_occ   = fifo_cnt_reg + {1'b0, rd_pend_reg};
    assign fifo_push  = rd_pend_reg && (state_reg == S_STREAM);
    assign fifo_pop   = lb_in_valid && lb_in_ready;
    assign cmd_accept = (state_reg == S_IDLE) && cmd_valid && !cmd_bad;
    assign last_pop   = (popped_reg == total_reg - PIX_ONE);
    assign last_ch    = (ch_reg == chans_reg - CH_ONE);
    assign drain_done = (seen_reg == expected_reg);
    // A popped pixel completes a window when it is the bottom-right corner of
    // a stride-aligned 3x3 footprint.
    assign win_hit    = (row_reg >= ROW_TWO) && (col_reg >= COL_TWO) &&
                        (row_mod_reg == '0) && (col_mod_reg == '0);

    // Command legality check against the configured image/channel limits
    always_comb begin
        cmd_bad = 1'b0;
        if ((32'(cmd_img_h) < 32'd3) || (32'(cmd_img_h) > 32'(MAX_IMG_H)))
            cmd_bad = 1'b1;
        if ((32'(cmd_img_w) < 32'd3) || (32'(cmd_img_w) > 32'(MAX_IMG_W)))
            cmd_bad = 1'b1;
        if ((cmd_channels == '0) || (32'(cmd_channels) > 32'(MAX_CH)))
            cmd_bad = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; abort overrides every busy state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (cmd_accept) state_next = S_START;
            S_START:  state_next = S_STREAM;
            S_STREAM: if (fifo_pop && last_pop) state_next = S_DRAIN;
            // Restarting the line buffer before all windows are out would
            // discard a window still pending downstream.
            S_DRAIN:  if (drain_done) state_next = S_NEXT;
            S_NEXT:   state_next = last_ch ? S_DONE : S_START;
            S_DONE:   state_next = S_IDLE;
            S_ABORT:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort && (state_reg != S_IDLE) && (state_reg != S_ABORT))
            state_next = S_ABORT;
    end

    // Output decode from state and datapath status
    always_comb begin
        cmd_ready     = (state_reg == S_IDLE);
        busy          = (state_reg != S_IDLE);
        done          = (state_reg == S_DONE);
        lb_start      = (state_reg == S_START) || (state_reg == S_ABORT);
        lb_in_valid   = (state_reg == S_STREAM) && (fifo_cnt_reg != 2'd0);
        lb_in_data    = lb_in_valid ? fifo_mem[fifo_rd_ptr_reg] : '0;
        mem_rd_en     = (state_reg == S_STREAM) && !abort &&
                        (issued_reg < total_reg) && (fifo_occ < 2'd2);
        mem_rd_addr   = addr_reg;
        lb_cfg_img_h  = cfg_h_reg;
        lb_cfg_img_w  = cfg_w_reg;
        lb_cfg_stride = cfg_stride_reg;
        out_channel   = ch_reg;
        err           = err_reg;
    end

    // Command latch, channel index, read address and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_h_reg      <= '0;
            cfg_w_reg      <= '0;
            cfg_stride_reg <= '0;
            chans_reg      <= '0;
            ch_reg         <= '0;
            total_reg      <= '0;
            addr_reg       <= '0;
            err_reg        <= 1'b0;
        end else begin
            err_reg <= (state_reg == S_IDLE) && cmd_valid && cmd_bad;
            if (cmd_accept) begin
                cfg_h_reg      <= cmd_img_h;
                cfg_w_reg      <= cmd_img_w;
                cfg_stride_reg <= (cmd_stride == '0) ? ROW_ONE : cmd_stride;
                chans_reg      <= cmd_channels;
                ch_reg         <= '0;
                total_reg      <= PIX_W'(cmd_img_h) * PIX_W'(cmd_img_w);
                addr_reg       <= cmd_base_addr;
            end else begin
                // Addresses run on across channels; the map is channel-major.
                if (mem_rd_en)
                    addr_reg <= addr_reg + ADDR_ONE;
                if ((state_reg == S_NEXT) && !last_ch)
                    ch_reg <= ch_reg + CH_ONE;
            end
        end
    end

    // Skid FIFO pointers/count and the one-deep read-pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_cnt_reg    <= 2'd0;
            rd_pend_reg     <= 1'b0;
        end else if ((state_reg == S_ABORT) || (state_reg == S_START)) begin
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_cnt_reg    <= 2'd0;
            rd_pend_reg     <= 1'b0;
        end else begin
            rd_pend_reg <= mem_rd_en;
            if (fifo_push) fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            if (fifo_pop)  fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    // Skid FIFO storage: captures SRAM data the cycle after each read
    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[fifo_wr_ptr_reg] <= mem_rd_data;
    end

    // Per-channel read/pop counts, shadow raster position and window prediction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_reg   <= '0;
            popped_reg   <= '0;
            expected_reg <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            row_mod_reg  <= '0;
            col_mod_reg  <= '0;
        end else if (state_reg == S_START) begin
            issued_reg   <= '0;
            popped_reg   <= '0;
            expected_reg <= '0;
            row_reg      <= '0;
            col_reg      <= '0;
            row_mod_reg  <= '0;
            col_mod_reg  <= '0;
        end else begin
            if (mem_rd_en)
                issued_reg <= issued_reg + PIX_ONE;
            if (fifo_pop) begin
                popped_reg <= popped_reg + PIX_ONE;
                if (win_hit)
                    expected_reg <= expected_reg + PIX_ONE;
                // Mod counters hold at 0 until the first full window row/col
                // and then wrap at stride, replacing a divider.
                if (col_reg == cfg_w_reg - COL_ONE) begin
                    col_reg     <= '0;
                    col_mod_reg <= '0;
                    row_reg     <= row_reg + ROW_ONE;
                    if (row_reg >= ROW_TWO)
                        row_mod_reg <= (row_mod_reg == cfg_stride_reg - ROW_ONE) ?
                                       '0 : row_mod_reg + ROW_ONE;
                end else begin
                    col_reg <= col_reg + COL_ONE;
                    if (col_reg >= COL_TWO)
                        col_mod_reg <= (col_mod_reg == cfg_stride_reg - ROW_ONE) ?
                                       '0 : col_mod_reg + ROW_ONE;
                end
            end
        end
    end

    // Count windows consumed downstream; never run past the prediction in DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            seen_reg <= '0;
        else if (state_reg == S_START)
            seen_reg <= '0;
        else if (lb_win_fire && (state_reg != S_IDLE) &&
                 !((state_reg == S_DRAIN) && drain_done))
            seen_reg <= seen_reg + PIX_ONE;
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_drain_reg;

    // Saturating stall/drain cycle counters, cleared when a layer is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_reg <= '0;
            perf_drain_reg <= '0;
        end else if (cmd_accept) begin
            perf_stall_reg <= '0;
            perf_drain_reg <= '0;
        end else begin
            if ((state_reg == S_STREAM) && (fifo_cnt_reg != 2'd0) && !lb_in_ready &&
                (perf_stall_reg != 32'hFFFF_FFFF))
                perf_stall_reg <= perf_stall_reg + 32'd1;
            if ((state_reg == S_DRAIN) && (perf_drain_reg != 32'hFFFF_FFFF))
                perf_drain_reg <= perf_drain_reg + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_reg;
    assign perf_drain_cycles = perf_drain_reg;
`endif

endmodule

// File: tb/tb_lb3x3_channel_sequencer.sv
// tb_lb3x3_channel_sequencer
// Directed + randomized bench: SRAM model, line-buffer window model with
// random delay, and a reference built from raster-order arithmetic.
module tb_lb3x3_channel_sequencer;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [7:0]         cmd_img_h = '0;
    logic [7:0]         cmd_img_w = '0;
    logic [7:0]         cmd_stride = '0;
    logic [10:0]        cmd_channels = '0;
    logic [19:0]        cmd_base_addr = '0;
    logic               abort = 1'b0;
    logic               mem_rd_en;
    logic [19:0]        mem_rd_addr;
    logic signed [7:0]  mem_rd_data = '0;
    logic               lb_start;
    logic [7:0]         lb_cfg_img_h;
    logic [7:0]         lb_cfg_img_w;
    logic [7:0]         lb_cfg_stride;
    logic               lb_in_valid;
    logic               lb_in_ready = 1'b1;
    logic signed [7:0]  lb_in_data;
    logic               lb_win_fire = 1'b0;
    logic [10:0]        out_channel;
    logic               busy;
    logic               done;
    logic               err;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0]        perf_stall_cycles;
    logic [31:0]        perf_drain_cycles;
`endif

    lb3x3_channel_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_img_h     (cmd_img_h),
        .cmd_img_w     (cmd_img_w),
        .cmd_stride    (cmd_stride),
        .cmd_channels  (cmd_channels),
        .cmd_base_addr (cmd_base_addr),
        .abort         (abort),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .lb_start      (lb_start),
        .lb_cfg_img_h  (lb_cfg_img_h),
        .lb_cfg_img_w  (lb_cfg_img_w),
        .lb_cfg_stride (lb_cfg_stride),
        .lb_in_valid   (lb_in_valid),
        .lb_in_ready   (lb_in_ready),
        .lb_in_data    (lb_in_data),
        .lb_win_fire   (lb_win_fire),
        .out_channel   (out_channel),
        .busy          (busy),
        .done          (done),
`ifdef SEQ_PERF_CNT_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_drain_cycles (perf_drain_cycles),
`endif
        .err           (err)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    int n_cmp = 0;
    int n_fail = 0;
    int m_h = 3, m_w = 3, m_s = 1, m_c = 1, m_base = 0;
    int n_reads = 0, n_pix = 0, n_starts = 0, n_done = 0, n_err = 0;
    int fires_total = 0;
    int max_dly = 0;
    bit rnd_ready = 1'b0;
    bit aborting = 1'b0;
    int cyc_cnt = 0;
    int fire_q[$];
    logic signed [7:0] sram [0:4095];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // SRAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= sram[mem_rd_addr[11:0]];
    end

    // Line-buffer side: random ready, window fires released after their delay
    always @(posedge clk) begin
        #1;
        cyc_cnt++;
        lb_in_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (fire_q.size() > 0 && fire_q[0] <= cyc_cnt) begin
            lb_win_fire = 1'b1;
            void'(fire_q.pop_front());
            fires_total++;
        end else begin
            lb_win_fire = 1'b0;
        end
    end

    // Monitor: read order, pixel content, window generation, start discipline
    always @(negedge clk) begin
        int k, r, c;
        if (rst_n) begin
            if (mem_rd_en) begin
                check("rd_addr", mem_rd_addr, (m_base + n_reads) & 32'hFFFFF);
                n_reads++;
            end
            if (lb_in_valid && lb_in_ready) begin
                check("pix_data", lb_in_data, sram[(m_base + n_pix) & 32'hFFF]);
                k = n_pix % (m_h * m_w);
                r = k / m_w;
                c = k % m_w;
                if (r >= 2 && c >= 2 && (r - 2) % m_s == 0 && (c - 2) % m_s == 0)
                    fire_q.push_back(cyc_cnt + int'($urandom_range(0, max_dly)));
                n_pix++;
            end
            if (mem_rd_en)
                check("outstanding", (n_reads - n_pix <= 2), 1);
            if (lb_start) begin
                n_starts++;
                if (!aborting) begin
                    check("start_ch", out_channel, n_starts - 1);
                    check("start_drained", fire_q.size() + int'(lb_win_fire), 0);
                end
            end
            if (done) n_done++;
            if (err)  n_err++;
        end
    end

    task automatic send_cmd(input int h, input int w, input int s, input int c, input int base);
        @(posedge clk); #1;
        cmd_valid     = 1'b1;
        cmd_img_h     = 8'(h);
        cmd_img_w     = 8'(w);
        cmd_stride    = 8'(s);
        cmd_channels  = 11'(c);
        cmd_base_addr = 20'(base);
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic set_model(input int h, input int w, input int s, input int c,
                             input int base, input bit rnd, input int dly);
        m_h = h; m_w = w; m_s = (s == 0) ? 1 : s; m_c = c; m_base = base;
        n_reads = 0; n_pix = 0; n_starts = 0; n_done = 0; n_err = 0;
        fires_total = 0; rnd_ready = rnd; max_dly = dly;
    endtask

    task automatic run_layer(input int h, input int w, input int s, input int c,
                             input int base, input bit rnd, input int dly);
        int exp_win, wc;
        set_model(h, w, s, c, base, rnd, dly);
        exp_win = ((h - 3) / m_s + 1) * ((w - 3) / m_s + 1) * c;
        $display("layer H=%0d W=%0d S=%0d C=%0d base=%05h windows=%0d", h, w, s, c, base, exp_win);
        send_cmd(h, w, s, c, base);
        @(negedge clk);
        check("cfg_h", lb_cfg_img_h, h);
        check("cfg_w", lb_cfg_img_w, w);
        check("cfg_stride", lb_cfg_stride, m_s);
        check("busy_run", busy, 1);
        wc = 0;
        do begin
            @(negedge clk);
            wc++;
        end while (!done && wc < 5000);
        #1;
        check("done_seen", done, 1);
        check("done_once", n_done, 1);
        check("reads", n_reads, h * w * c);
        check("pixels", n_pix, h * w * c);
        check("starts", n_starts, c);
        check("windows", fires_total, exp_win);
        check("no_err", n_err, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    task automatic bad_cmd(input int h, input int w, input int c);
        set_model(3, 3, 1, 1, 0, 1'b0, 0);
        $display("bad command H=%0d W=%0d C=%0d", h, w, c);
        send_cmd(h, w, 1, c, 0);
        @(negedge clk);
        check("err_pulse", err, 1);
        check("err_ready", cmd_ready, 1);
        check("err_busy", busy, 0);
        repeat (3) @(negedge clk);
        #1;
        check("err_once", n_err, 1);
        check("err_reads", n_reads, 0);
        check("err_starts", n_starts, 0);
    endtask

    initial begin
        int wc, starts_before, reads_before;
        for (int i = 0; i < 4096; i++) sram[i] = 8'($urandom);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_lb_start", lb_start, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_in_valid", lb_in_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_channel", out_channel, 0);
        check("rst_cfg_h", lb_cfg_img_h, 0);
        check("rst_cfg_stride", lb_cfg_stride, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed layers
        run_layer(4, 4, 1, 1, 'h100, 1'b0, 0);
        run_layer(5, 5, 2, 3, 0, 1'b0, 0);
        run_layer(4, 4, 1, 1, 'h100, 1'b1, 10);

        // Illegal commands
        bad_cmd(2, 8, 1);
        bad_cmd(8, 8, 0);
        bad_cmd(8, 225, 1);

        // Abort mid-stream of channel 1 of 3
        set_model(5, 5, 1, 3, 'h200, 1'b0, 2);
        $display("abort layer H=5 W=5 C=3");
        send_cmd(5, 5, 1, 3, 'h200);
        wc = 0;
        do begin
            @(negedge clk);
            wc++;
        end while (!(n_starts >= 2 && n_pix >= 31) && wc < 2000);
        #1;
        check("abort_reach_ch1", out_channel, 1);
        aborting = 1'b1;
        @(posedge clk); #1;
        abort = 1'b1;
        starts_before = n_starts;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_start", lb_start, 1);
        check("abort_rd_en", mem_rd_en, 0);
        #1;
        reads_before = n_reads;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 1);
        repeat (5) @(negedge clk);
        #1;
        check("abort_one_start", n_starts, starts_before + 1);
        check("abort_no_done", n_done, 0);
        check("abort_no_reads", n_reads, reads_before);
        fire_q.delete();
        aborting = 1'b0;
        run_layer(3, 3, 1, 1, 'h300, 1'b0, 0);

        // Stride 0 behaves as stride 1
        run_layer(3, 3, 0, 1, 'h40, 1'b1, 3);

        // Random layers, first one wrapping the address space
        for (int i = 0; i < 3; i++)
            run_layer(int'($urandom_range(3, 8)), int'($urandom_range(3, 8)),
                      int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                      (i == 0) ? 'hFFFF8 : int'($urandom_range(0, 'hFFFFF)),
                      1'b1, int'($urandom_range(0, 10)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
